// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle ramp sequencer for the PWM driver.
// Slews duty toward target once per 256-clock frame; handles stop/fault.
module pwm_ramp_ctrl #(
  parameter int unsigned STEP = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [7:0] req_duty,
  output logic       req_ready,
  input  logic       stop,
  input  logic       fault,
  input  logic       fault_clr,
  output logic [7:0] duty_out,
  output logic       pwm_en_n,
  output logic       busy,
  output logic       at_target
);

  localparam logic [8:0] STEP9 = 9'(STEP);

  typedef enum logic [2:0] {
    IDLE,
    RAMP,
    HOLD,
    STOP_RAMP,
    FAULT
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q;
  logic [7:0] duty_q, duty_d;
  logic [7:0] tgt_q, tgt_d;
  logic       en_n_q, en_n_d;
  logic       rdy_q, busy_q, at_q;
  logic       tick, accept;
  logic [8:0] up9, dn_lim9;
  logic [7:0] step_nxt;

  assign tick   = (cnt_q == 8'hFF);
  assign accept = req_valid & rdy_q;

  // One clamped step toward target; 9-bit sums keep the clamp exact
  always_comb begin
    up9      = {1'b0, duty_q} + STEP9;
    dn_lim9  = {1'b0, tgt_q} + STEP9;
    step_nxt = duty_q;
    unique case (1'b1)
      (duty_q < tgt_q):
        step_nxt = (up9 > {1'b0, tgt_q}) ? tgt_q : up9[7:0];
      (duty_q > tgt_q):
        step_nxt = ({1'b0, duty_q} < dn_lim9) ? tgt_q
                 : duty_q - STEP9[7:0];
      default: step_nxt = duty_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    en_n_d  = en_n_q;
    if (fault) begin
      state_d = FAULT;
      duty_d  = 8'd0;
      tgt_d   = 8'd0;
      en_n_d  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            tgt_d = req_duty;
            if (req_duty != 8'd0) begin
              state_d = RAMP;
              en_n_d  = 1'b0;
            end
          end
        end
        RAMP, HOLD: begin
          if (stop) begin
            tgt_d   = 8'd0;
            state_d = STOP_RAMP;
          end else if (accept) begin
            tgt_d   = req_duty;
            state_d = (req_duty == duty_q) ? HOLD : RAMP;
          end else if (state_q == RAMP && tick) begin
            duty_d = step_nxt;
            if (step_nxt == tgt_q) state_d = HOLD;
          end
        end
        STOP_RAMP: begin
          if (tick) begin
            duty_d = step_nxt;
            if (step_nxt == 8'd0) begin
              state_d = IDLE;
              en_n_d  = 1'b1;
            end
          end
        end
        FAULT: begin
          if (fault_clr) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      duty_q  <= 8'd0;
      tgt_q   <= 8'd0;
      en_n_q  <= 1'b1;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      at_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_q + 8'd1;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      en_n_q  <= en_n_d;
      rdy_q   <= (state_d != STOP_RAMP) && (state_d != FAULT);
      busy_q  <= (state_d == RAMP) || (state_d == STOP_RAMP);
      at_q    <= (state_d == HOLD);
    end
  end

  assign req_ready = rdy_q;
  assign duty_out  = duty_q;
  assign pwm_en_n  = en_n_q;
  assign busy      = busy_q;
  assign at_target = at_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: per-tick expectations queued at stimulus time,
// popped and compared on each frame-tick edge.
module tb_pwm_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [7:0] req_duty = 8'd0;
  logic       stop = 1'b0;
  logic       fault = 1'b0;
  logic       fault_clr = 1'b0;
  logic       req_ready, pwm_en_n, busy, at_target;
  logic [7:0] duty_out;

  logic       b_valid = 1'b0;
  logic [7:0] b_duty = 8'd0;
  logic       b_ready, b_en_n, b_busy, b_at;
  logic [7:0] b_out;

  int checks = 0;
  int failures = 0;
  bit sel2 = 1'b0;
  logic [7:0] tb_cnt;

  typedef struct {
    string      tag;
    logic [7:0] duty;
    logic       en_n;
    logic       busy;
    logic       at;
    logic       rdy;
  } exp_t;

  exp_t exp_q[$];

  pwm_ramp_ctrl #(.STEP(8)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_duty(req_duty),
    .req_ready(req_ready), .stop(stop),
    .fault(fault), .fault_clr(fault_clr),
    .duty_out(duty_out), .pwm_en_n(pwm_en_n),
    .busy(busy), .at_target(at_target)
  );

  pwm_ramp_ctrl #(.STEP(255)) u_big (
    .clk(clk), .rst(rst),
    .req_valid(b_valid), .req_duty(b_duty),
    .req_ready(b_ready), .stop(1'b0),
    .fault(1'b0), .fault_clr(1'b0),
    .duty_out(b_out), .pwm_en_n(b_en_n),
    .busy(b_busy), .at_target(b_at)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) tb_cnt <= 8'd0;
    else     tb_cnt <= tb_cnt + 8'd1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input int d,
                      input bit en_n, input bit bz,
                      input bit at, input bit rdy);
    exp_t e;
    e.tag = tag; e.duty = 8'(d); e.en_n = en_n;
    e.busy = bz; e.at = at; e.rdy = rdy;
    exp_q.push_back(e);
  endtask

  task automatic cmp(input exp_t e);
    if (sel2) begin
      chk({e.tag, ".duty"}, 32'(b_out), 32'(e.duty));
      chk({e.tag, ".en_n"}, 32'(b_en_n), 32'(e.en_n));
      chk({e.tag, ".busy"}, 32'(b_busy), 32'(e.busy));
      chk({e.tag, ".at"}, 32'(b_at), 32'(e.at));
      chk({e.tag, ".rdy"}, 32'(b_ready), 32'(e.rdy));
    end else begin
      chk({e.tag, ".duty"}, 32'(duty_out), 32'(e.duty));
      chk({e.tag, ".en_n"}, 32'(pwm_en_n), 32'(e.en_n));
      chk({e.tag, ".busy"}, 32'(busy), 32'(e.busy));
      chk({e.tag, ".at"}, 32'(at_target), 32'(e.at));
      chk({e.tag, ".rdy"}, 32'(req_ready), 32'(e.rdy));
    end
  endtask

  // Advance to each tick edge (counter just wrapped) and compare
  task automatic drain();
    exp_t e;
    int n;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = 0;
      do begin
        cyc();
        n++;
      end while (tb_cnt != 8'd0 && n < 300);
      if (n >= 300) chk({e.tag, ".tick_wait"}, 32'(n), 32'd256);
      cmp(e);
    end
  endtask

  task automatic req(input int d);
    req_valid = 1'b1;
    req_duty  = 8'(d);
    cyc();
    req_valid = 1'b0;
  endtask

  initial begin
    cyc();
    cyc();
    cmp('{"reset", 8'd0, 1'b1, 1'b0, 1'b0, 1'b1});
    rst = 1'b0;

    // request 20 at counter 10
    while (tb_cnt != 8'd10) cyc();
    req(20);
    cmp('{"acc20", 8'd0, 1'b0, 1'b1, 1'b0, 1'b1});
    push("r20a", 8, 0, 1, 0, 1);
    push("r20b", 16, 0, 1, 0, 1);
    push("r20c", 20, 0, 0, 1, 1);
    drain();

    // stop from HOLD 20
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    cmp('{"stop20", 8'd20, 1'b0, 1'b1, 1'b0, 1'b0});
    push("s20a", 12, 0, 1, 0, 0);
    push("s20b", 4, 0, 1, 0, 0);
    push("s20c", 0, 1, 0, 0, 1);
    drain();

    // zero request in IDLE has no effect
    req(0);
    cmp('{"req0", 8'd0, 1'b1, 1'b0, 1'b0, 1'b1});

    // ramp to 200, retarget to 40 at duty 48
    req(200);
    for (int d = 8; d <= 48; d += 8) push("r200", d, 0, 1, 0, 1);
    drain();
    req(40);
    push("r40", 40, 0, 0, 1, 1);
    drain();

    // up to 100, then down to 90
    req(100);
    for (int d = 48; d <= 96; d += 8) push("r100", d, 0, 1, 0, 1);
    push("r100e", 100, 0, 0, 1, 1);
    drain();
    req(90);
    push("r90a", 92, 0, 1, 0, 1);
    push("r90b", 90, 0, 0, 1, 1);
    drain();

    // stop from 90: twelve ticks
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    for (int d = 82; d > 0; d -= 8) push("s90", d, 0, 1, 0, 0);
    push("s90e", 0, 1, 0, 0, 1);
    drain();

    // fault during ramp at 64
    req(200);
    for (int d = 8; d <= 64; d += 8) push("f64", d, 0, 1, 0, 1);
    drain();
    cyc();
    fault = 1'b1;
    cyc();
    cmp('{"fault", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    fault_clr = 1'b1;
    cyc();
    fault_clr = 1'b0;
    cmp('{"fclr_hi", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    fault = 1'b0;
    cyc();
    cmp('{"flow", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    fault_clr = 1'b1;
    cyc();
    fault_clr = 1'b0;
    cmp('{"fclr", 8'd0, 1'b1, 1'b0, 1'b0, 1'b1});

    // stop and request on the same edge in HOLD 8
    req(8);
    push("h8", 8, 0, 0, 1, 1);
    drain();
    stop = 1'b1;
    req_valid = 1'b1;
    req_duty = 8'd255;
    cyc();
    stop = 1'b0;
    req_valid = 1'b0;
    cmp('{"stopreq", 8'd8, 1'b0, 1'b1, 1'b0, 1'b0});
    push("sr_a", 0, 1, 0, 0, 1);
    push("sr_b", 0, 1, 0, 0, 1);
    drain();

    // async reset mid-ramp
    req(200);
    push("ar", 8, 0, 1, 0, 1);
    drain();
    repeat (5) cyc();
    #3 rst = 1'b1;
    #1 cmp('{"arst", 8'd0, 1'b1, 1'b0, 1'b0, 1'b1});
    cyc();
    rst = 1'b0;

    // STEP=255 instance: full swing in one tick
    sel2 = 1'b1;
    b_valid = 1'b1;
    b_duty = 8'd255;
    cyc();
    b_valid = 1'b0;
    cmp('{"big_acc", 8'd0, 1'b0, 1'b1, 1'b0, 1'b1});
    push("big255", 255, 0, 0, 1, 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
